// File: rtl/one_counter_pkg.sv
// Shared types and the reference popcount table for the 3-input ones counter.
package one_counter_pkg;

  localparam int CNT_W = 2;

  typedef logic [CNT_W-1:0] cnt_t;

  // Indexed by {a,b,c}; entry = {y1,y0}
  localparam cnt_t EXP_CNT [8] = '{
    2'b00, 2'b01, 2'b01, 2'b10,
    2'b01, 2'b10, 2'b10, 2'b11
  };

endpackage

// File: rtl/one_counter_3in_if.sv
// Signal bundle for driving/observing the ones counter from a single handle.
interface one_counter_3in_if;

  logic a;
  logic b;
  logic c;
  logic y1;
  logic y0;
  logic err;

  modport master (output a, b, c, input  y1, y0, err);
  modport slave  (input  a, b, c, output y1, y0, err);

endinterface

// File: rtl/one_counter_3in_switch.sv
// Switch-level popcount: static inverters plus transmission-gate muxes,
// so every node is actively driven by exactly one conducting path.
module ones_count_switch (
  input  logic a,
  input  logic b,
  input  logic c,
  output wire  y1,
  output wire  y0
);

  supply1 vdd;
  supply0 gnd;

  wire na, nb, nc;
  wire p, np, pr;
  wire s, ns;
  wire m, nm;

  pmos (na, vdd, a);  nmos (na, gnd, a);
  pmos (nb, vdd, b);  nmos (nb, gnd, b);
  pmos (nc, vdd, c);  nmos (nc, gnd, c);

  // p = a ^ b : select ~a when b=1, a when b=0
  nmos (p, na, b);   pmos (p, na, nb);
  nmos (p, a,  nb);  pmos (p, a,  b);

  pmos (np, vdd, p);  nmos (np, gnd, p);
  pmos (pr, vdd, np); nmos (pr, gnd, np);

  // s = p ^ c
  nmos (s, np, c);   pmos (s, np, nc);
  nmos (s, pr, nc);  pmos (s, pr, c);

  // m = p ? c : a  (when a==b the majority is a)
  nmos (m, c, pr);   pmos (m, c, np);
  nmos (m, a, np);   pmos (m, a, pr);

  pmos (ns, vdd, s);  nmos (ns, gnd, s);
  pmos (y0, vdd, ns); nmos (y0, gnd, ns);

  pmos (nm, vdd, m);  nmos (nm, gnd, m);
  pmos (y1, vdd, nm); nmos (y1, gnd, nm);

endmodule

// File: rtl/one_counter_3in.sv
// 3-input ones counter computed three ways (assign, gate, switch),
// cross-checked and registered; outputs always come from the assign path.
module one_counter_3in
  import one_counter_pkg::*;
#(
  parameter bit CHECK_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y1,
  output logic y0,
  output logic err
);

  logic asg_y1, asg_y0;
  wire  g_ab, g_ac, g_bc, g_y1, g_y0;
  wire  sw_y1_raw, sw_y0_raw;
  logic sw_y1, sw_y0;
  cnt_t asg_cnt, gate_cnt, sw_cnt;
  logic mismatch;
  logic y1_d, y0_d, err_d;
  logic y1_q, y0_q, err_q;

  assign asg_y1 = (a & b) | (a & c) | (b & c);
  assign asg_y0 = a ^ b ^ c;

  and (g_ab, a, b);
  and (g_ac, a, c);
  and (g_bc, b, c);
  or  (g_y1, g_ab, g_ac, g_bc);
  xor (g_y0, a, b, c);

  ones_count_switch u_sw (
    .a  (a),
    .b  (b),
    .c  (c),
    .y1 (sw_y1_raw),
    .y0 (sw_y0_raw)
  );

  // Plain-variable copies decouple the comparator from the switch nets
  assign sw_y1 = sw_y1_raw;
  assign sw_y0 = sw_y0_raw;

  assign asg_cnt  = {asg_y1, asg_y0};
  assign gate_cnt = {g_y1, g_y0};
  assign sw_cnt   = {sw_y1, sw_y0};

  assign mismatch = (|(asg_cnt ^ gate_cnt)) | (|(asg_cnt ^ sw_cnt));

  always_comb begin
    y1_d  = asg_y1;
    y0_d  = asg_y0;
    err_d = 1'b0;
    if (CHECK_EN) err_d = mismatch;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y1_q  <= 1'b0;
      y0_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      y1_q  <= y1_d;
      y0_q  <= y0_d;
      err_q <= err_d;
    end
  end

  assign y1  = y1_q;
  assign y0  = y0_q;
  assign err = err_q;

  a_tbl: assert property (@(posedge clk) disable iff (rst)
    asg_cnt == EXP_CNT[{a, b, c}]);

endmodule

// File: tb/tb_one_counter_3in.sv
// Directed and randomized-code checks of the 3-input ones counter.
module tb_one_counter_3in;
  import one_counter_pkg::*;

  localparam int CLK_PERIOD = 10;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  one_counter_3in_if ifc ();

  one_counter_3in #(.CHECK_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .a   (ifc.a),
    .b   (ifc.b),
    .c   (ifc.c),
    .y1  (ifc.y1),
    .y0  (ifc.y0),
    .err (ifc.err)
  );

  always #(CLK_PERIOD/2) clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic [2:0] v);
    {ifc.a, ifc.b, ifc.c} = v;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] walk_in  [8] = '{3'b000, 3'b100, 3'b110, 3'b111,
                               3'b101, 3'b001, 3'b011, 3'b010};
  logic [1:0] walk_exp [8] = '{2'b00, 2'b01, 2'b10, 2'b11,
                               2'b10, 2'b01, 2'b10, 2'b01};

  initial begin
    rst = 1'b1;
    drive(3'b111);
    #2;
    chk("rst_cnt", {2'b00, ifc.y1, ifc.y0}, 4'h0);
    chk("rst_err", {3'b000, ifc.err}, 4'h0);

    @(negedge clk);
    rst = 1'b0;
    after_edge();
    chk("rel_cnt", {2'b00, ifc.y1, ifc.y0}, 4'h3);
    chk("rel_err", {3'b000, ifc.err}, 4'h0);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(walk_in[i]);
      after_edge();
      chk("walk_cnt", {2'b00, ifc.y1, ifc.y0}, {2'b00, walk_exp[i]});
      chk("walk_err", {3'b000, ifc.err}, 4'h0);
      repeat (9) @(posedge clk);
    end

    for (int i = 0; i < 1000; i++) begin
      logic [2:0] v;
      v = 3'($urandom_range(0, 7));
      @(negedge clk);
      drive(v);
      after_edge();
      chk("exh_cnt", {2'b00, ifc.y1, ifc.y0}, {2'b00, EXP_CNT[v]});
      chk("exh_err", {3'b000, ifc.err}, 4'h0);
    end

    @(negedge clk);
    drive(3'b111);
    after_edge();
    chk("mid_pre", {2'b00, ifc.y1, ifc.y0}, 4'h3);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_async", {2'b00, ifc.y1, ifc.y0}, 4'h0);
    chk("mid_err", {3'b000, ifc.err}, 4'h0);
    after_edge();
    chk("mid_hold", {2'b00, ifc.y1, ifc.y0}, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rel", {2'b00, ifc.y1, ifc.y0}, 4'h0);
    after_edge();
    chk("mid_resume", {2'b00, ifc.y1, ifc.y0}, 4'h3);

    @(negedge clk);
    drive(3'b111);
    force dut.sw_y0 = 1'b0;
    after_edge();
    chk("flt1_err", {3'b000, ifc.err}, 4'h1);
    chk("flt1_cnt", {2'b00, ifc.y1, ifc.y0}, 4'h3);
    @(negedge clk);
    drive(3'b000);
    force dut.sw_y0 = 1'b1;
    after_edge();
    chk("flt2_err", {3'b000, ifc.err}, 4'h1);
    chk("flt2_cnt", {2'b00, ifc.y1, ifc.y0}, 4'h0);
    @(negedge clk);
    release dut.sw_y0;
    drive(3'b100);
    after_edge();
    chk("flt_clr_err", {3'b000, ifc.err}, 4'h0);
    chk("flt_clr_cnt", {2'b00, ifc.y1, ifc.y0}, 4'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
